// File: rtl/jedro_1_pkg.sv
// jedro_1 decode: shared opcode, class and ALU-op encodings.
// Immediate helpers shared by the decoder.
package jedro_1_pkg;

  localparam logic [6:0] OPC_LOAD    = 7'h03;
  localparam logic [6:0] OPC_MISCMEM = 7'h0F;
  localparam logic [6:0] OPC_OPIMM   = 7'h13;
  localparam logic [6:0] OPC_AUIPC   = 7'h17;
  localparam logic [6:0] OPC_STORE   = 7'h23;
  localparam logic [6:0] OPC_OP      = 7'h33;
  localparam logic [6:0] OPC_LUI     = 7'h37;
  localparam logic [6:0] OPC_BRANCH  = 7'h63;
  localparam logic [6:0] OPC_JALR    = 7'h67;
  localparam logic [6:0] OPC_JAL     = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM  = 7'h73;

  typedef enum logic [3:0] {
    CLS_LOAD, CLS_STORE, CLS_OPIMM, CLS_OP,
    CLS_LUI, CLS_AUIPC, CLS_BRANCH, CLS_JAL,
    CLS_JALR, CLS_MISCMEM, CLS_SYSTEM, CLS_CSR
  } instr_class_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT,
    ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_e;

  function automatic logic [31:0] imm_i(input logic [31:0] w);
    return {{20{w[31]}}, w[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] w);
    return {{20{w[31]}}, w[31:25], w[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] w);
    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] w);
    return {w[31:12], 12'd0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] w);
    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
  endfunction

  // alt selects SUB/SRA; callers mask it for I-type ADDI.
  function automatic alu_op_e f3_alu(input logic [2:0] f3,
                                     input logic alt);
    alu_op_e op;
    op = ALU_ADD;
    case (f3)
      3'd0: op = alt ? ALU_SUB : ALU_ADD;
      3'd1: op = ALU_SLL;
      3'd2: op = ALU_SLT;
      3'd3: op = ALU_SLTU;
      3'd4: op = ALU_XOR;
      3'd5: op = alt ? ALU_SRA : ALU_SRL;
      3'd6: op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/jedro_1_decoder_logic.sv
// jedro_1 combinational RV32I word-to-fields decode.
// Zicsr decode is enabled by defining JEDRO_1_ZICSR_EN.
module jedro_1_decoder_logic
  import jedro_1_pkg::*;
#(
  parameter int RF_ADDR_WIDTH = 5
) (
  input  logic [31:0]              instr,
  output logic [3:0]               instr_class,
  output logic [3:0]               alu_op,
  output logic [2:0]               funct3,
  output logic [RF_ADDR_WIDTH-1:0] rs1_addr,
  output logic [RF_ADDR_WIDTH-1:0] rs2_addr,
  output logic [RF_ADDR_WIDTH-1:0] rd_addr,
  output logic                     rd_we,
  output logic [31:0]              imm,
  output logic                     illegal
);

  localparam logic [4:0] RF_MASK =
    5'((32'd1 << RF_ADDR_WIDTH) - 32'd1);

  logic [6:0]   opcode;
  logic [6:0]   funct7;
  logic [2:0]   f3;
  logic [4:0]   rs1_f, rs2_f, rd_f;
  instr_class_e cls;
  alu_op_e      alu;
  logic         use_rs1, use_rs2, use_rd;
  logic         wr, bad_enc, bad_reg;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign funct7 = instr[31:25];
  assign rs1_f  = instr[19:15];
  assign rs2_f  = instr[24:20];
  assign rd_f   = instr[11:7];

  // Per-opcode class, ALU op, immediate and encoding legality.
  always_comb begin
    cls     = CLS_SYSTEM;
    alu     = ALU_ADD;
    imm     = 32'd0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    wr      = 1'b0;
    bad_enc = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        cls     = CLS_LOAD;
        imm     = imm_i(instr);
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        wr      = 1'b1;
        bad_enc = (f3 == 3'd3) | (f3 == 3'd6) | (f3 == 3'd7);
      end
      OPC_STORE: begin
        cls     = CLS_STORE;
        imm     = imm_s(instr);
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        bad_enc = (f3 > 3'd2);
      end
      OPC_OPIMM: begin
        cls     = CLS_OPIMM;
        imm     = imm_i(instr);
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        wr      = 1'b1;
        alu     = f3_alu(f3, (f3 == 3'd5) & funct7[5]);
        if (f3 == 3'd1)
          bad_enc = (funct7 != 7'h00);
        else if (f3 == 3'd5)
          bad_enc = (funct7 != 7'h00) & (funct7 != 7'h20);
      end
      OPC_OP: begin
        cls     = CLS_OP;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
        wr      = 1'b1;
        alu     = f3_alu(f3, funct7[5]);
        if (funct7 == 7'h20)
          bad_enc = (f3 != 3'd0) & (f3 != 3'd5);
        else
          bad_enc = (funct7 != 7'h00);
      end
      OPC_LUI: begin
        cls    = CLS_LUI;
        alu    = ALU_PASS_B;
        imm    = imm_u(instr);
        use_rd = 1'b1;
        wr     = 1'b1;
      end
      OPC_AUIPC: begin
        cls    = CLS_AUIPC;
        imm    = imm_u(instr);
        use_rd = 1'b1;
        wr     = 1'b1;
      end
      OPC_BRANCH: begin
        cls     = CLS_BRANCH;
        alu     = ALU_SUB;
        imm     = imm_b(instr);
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        bad_enc = (f3 == 3'd2) | (f3 == 3'd3);
      end
      OPC_JAL: begin
        cls    = CLS_JAL;
        imm    = imm_j(instr);
        use_rd = 1'b1;
        wr     = 1'b1;
      end
      OPC_JALR: begin
        cls     = CLS_JALR;
        imm     = imm_i(instr);
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        wr      = 1'b1;
        bad_enc = (f3 != 3'd0);
      end
      OPC_MISCMEM: begin
        cls     = CLS_MISCMEM;
        imm     = imm_i(instr);
        bad_enc = (f3[2:1] != 2'd0);
      end
      OPC_SYSTEM: begin
        cls = CLS_SYSTEM;
        imm = imm_i(instr);
        if (f3 == 3'd0)
          bad_enc = (instr != 32'h0000_0073) &
                    (instr != 32'h0010_0073);
`ifdef JEDRO_1_ZICSR_EN
        else if (f3 != 3'd4) begin
          cls     = CLS_CSR;
          imm     = {20'd0, instr[31:20]};
          use_rd  = 1'b1;
          wr      = 1'b1;
          use_rs1 = ~f3[2];
        end else
          bad_enc = 1'b1;
`else
        else
          bad_enc = 1'b1;
`endif
      end
      default: bad_enc = 1'b1;
    endcase
  end

  assign bad_reg = (use_rs1 & |(rs1_f & ~RF_MASK)) |
                   (use_rs2 & |(rs2_f & ~RF_MASK)) |
                   (use_rd  & |(rd_f  & ~RF_MASK));

  assign illegal     = bad_enc | bad_reg |
                       (instr[1:0] != 2'b11);
  assign rd_we       = wr & ~illegal & (rd_f != 5'd0);
  assign instr_class = cls;
  assign alu_op      = alu;
  assign funct3      = f3;
  assign rs1_addr    = rs1_f[RF_ADDR_WIDTH-1:0];
  assign rs2_addr    = rs2_f[RF_ADDR_WIDTH-1:0];
  assign rd_addr     = rd_f[RF_ADDR_WIDTH-1:0];

endmodule

// File: rtl/jedro_1_decode_stage.sv
// jedro_1 registered decode stage: output register plus skid buffer.
// JEDRO_1_ZICSR_EN enables CSR decode inside jedro_1_decoder_logic.
module jedro_1_decode_stage
  import jedro_1_pkg::*;
#(
  parameter int RF_ADDR_WIDTH = 5,
  parameter int XLEN          = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [31:0]              instr_rdata_i,
  input  logic [XLEN-1:0]          pc_i,
  input  logic                     instr_valid_i,
  output logic                     instr_ready_o,
  input  logic                     flush_i,
  output logic                     dec_valid_o,
  input  logic                     dec_ready_i,
  output logic [XLEN-1:0]          pc_o,
  output logic [3:0]               instr_class_o,
  output logic [3:0]               alu_op_o,
  output logic [2:0]               funct3_o,
  output logic [RF_ADDR_WIDTH-1:0] rs1_addr_o,
  output logic [RF_ADDR_WIDTH-1:0] rs2_addr_o,
  output logic [RF_ADDR_WIDTH-1:0] rd_addr_o,
  output logic                     rd_we_o,
  output logic [XLEN-1:0]          imm_o,
  output logic                     illegal_insn_o
);

  logic                     or_valid, sb_valid, rdy_q;
  logic                     sb_next, accept, or_free, load_or;
  logic [31:0]              sb_word, src_word;
  logic [XLEN-1:0]          sb_pc, src_pc;
  logic [3:0]               d_class, d_alu;
  logic [2:0]               d_f3;
  logic [RF_ADDR_WIDTH-1:0] d_rs1, d_rs2, d_rd;
  logic                     d_we, d_ill;
  logic [31:0]              d_imm;

  assign accept   = instr_valid_i & rdy_q;
  assign or_free  = ~or_valid | dec_ready_i;
  assign load_or  = or_free & (sb_valid | accept);
  assign src_word = sb_valid ? sb_word : instr_rdata_i;
  assign src_pc   = sb_valid ? sb_pc : pc_i;

  jedro_1_decoder_logic #(
    .RF_ADDR_WIDTH(RF_ADDR_WIDTH)
  ) u_dec (
    .instr      (src_word),
    .instr_class(d_class),
    .alu_op     (d_alu),
    .funct3     (d_f3),
    .rs1_addr   (d_rs1),
    .rs2_addr   (d_rs2),
    .rd_addr    (d_rd),
    .rd_we      (d_we),
    .imm        (d_imm),
    .illegal    (d_ill)
  );

  // Skid occupancy after this edge; drives the registered ready.
  always_comb begin
    sb_next = 1'b0;
    if (!or_free)
      sb_next = sb_valid | accept;
  end

  // Valid flags and ready; flush overrides every transfer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      or_valid <= 1'b0;
      sb_valid <= 1'b0;
      rdy_q    <= 1'b0;
    end else if (flush_i) begin
      or_valid <= 1'b0;
      sb_valid <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      if (or_free)
        or_valid <= sb_valid | accept;
      sb_valid <= sb_next;
      rdy_q    <= ~sb_next;
    end
  end

  // Data registers load only on a move; they hold otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sb_word        <= 32'd0;
      sb_pc          <= '0;
      pc_o           <= '0;
      instr_class_o  <= 4'd0;
      alu_op_o       <= 4'd0;
      funct3_o       <= 3'd0;
      rs1_addr_o     <= '0;
      rs2_addr_o     <= '0;
      rd_addr_o      <= '0;
      rd_we_o        <= 1'b0;
      imm_o          <= '0;
      illegal_insn_o <= 1'b0;
    end else if (!flush_i) begin
      if (accept && !or_free) begin
        sb_word <= instr_rdata_i;
        sb_pc   <= pc_i;
      end
      if (load_or) begin
        pc_o           <= src_pc;
        instr_class_o  <= d_class;
        alu_op_o       <= d_alu;
        funct3_o       <= d_f3;
        rs1_addr_o     <= d_rs1;
        rs2_addr_o     <= d_rs2;
        rd_addr_o      <= d_rd;
        rd_we_o        <= d_we;
        imm_o          <= d_imm;
        illegal_insn_o <= d_ill;
      end
    end
  end

  assign dec_valid_o   = or_valid;
  assign instr_ready_o = rdy_q;

endmodule

// File: tb/tb_jedro_1_decode_stage.sv
// Bench for jedro_1_decode_stage: decode vectors, flow control, flush.
// Runs an RV32I and an RV32E instance on shared inputs.
module tb_jedro_1_decode_stage;
  import jedro_1_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instr_valid;
  logic        flush;
  logic        dec_ready;

  logic        ready, dv, we, ill;
  logic [31:0] pc_out, imm;
  logic [3:0]  cls, alu;
  logic [2:0]  f3;
  logic [4:0]  rs1, rs2, rd;

  logic        e_ready, e_dv, e_we, e_ill;
  logic [31:0] e_pc, e_imm;
  logic [3:0]  e_cls, e_alu;
  logic [2:0]  e_f3;
  logic [3:0]  e_rs1, e_rs2, e_rd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  jedro_1_decode_stage #(.RF_ADDR_WIDTH(5), .XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .instr_rdata_i(instr), .pc_i(pc),
    .instr_valid_i(instr_valid), .instr_ready_o(ready),
    .flush_i(flush),
    .dec_valid_o(dv), .dec_ready_i(dec_ready),
    .pc_o(pc_out), .instr_class_o(cls), .alu_op_o(alu),
    .funct3_o(f3), .rs1_addr_o(rs1), .rs2_addr_o(rs2),
    .rd_addr_o(rd), .rd_we_o(we), .imm_o(imm),
    .illegal_insn_o(ill)
  );

  jedro_1_decode_stage #(.RF_ADDR_WIDTH(4), .XLEN(32)) dut_e (
    .clk_i(clk), .rst_i(rst),
    .instr_rdata_i(instr), .pc_i(pc),
    .instr_valid_i(instr_valid), .instr_ready_o(e_ready),
    .flush_i(flush),
    .dec_valid_o(e_dv), .dec_ready_i(dec_ready),
    .pc_o(e_pc), .instr_class_o(e_cls), .alu_op_o(e_alu),
    .funct3_o(e_f3), .rs1_addr_o(e_rs1), .rs2_addr_o(e_rs2),
    .rd_addr_o(e_rd), .rd_we_o(e_we), .imm_o(e_imm),
    .illegal_insn_o(e_ill)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic        full;
    logic [3:0]  cls;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        we;
    logic        ill;
    logic        e_ill;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic [31:0] i, input logic fl,
    input logic [3:0] c, input logic [3:0] a,
    input logic [4:0] d, input logic [4:0] s1,
    input logic [4:0] s2, input logic [31:0] im,
    input logic w, input logic il, input logic eil);
    vec_t v;
    v = '{i, fl, c, a, d, s1, s2, im, w, il, eil};
    return v;
  endfunction

  // ADDI x(k+1), x0, k : rd identifies the word in order checks.
  function automatic logic [31:0] word(input int k);
    return {12'(k), 5'd0, 3'd0, 5'(k + 1), 7'h13};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n_in, n_out;
    logic acc, cons, drop_seen;

    vq.push_back(mk(32'hFFD08293, 1, CLS_OPIMM, ALU_ADD,
                    5, 1, 29, 32'hFFFFFFFD, 1, 0, 0));
    vq.push_back(mk(32'h002081B3, 1, CLS_OP, ALU_ADD,
                    3, 1, 2, 0, 1, 0, 0));
    vq.push_back(mk(32'h40218233, 1, CLS_OP, ALU_SUB,
                    4, 3, 2, 0, 1, 0, 0));
    vq.push_back(mk(32'h4043D313, 1, CLS_OPIMM, ALU_SRA,
                    6, 7, 4, 32'h404, 1, 0, 0));
    vq.push_back(mk(32'h12345537, 1, CLS_LUI, ALU_PASS_B,
                    10, 8, 3, 32'h12345000, 1, 0, 0));
    vq.push_back(mk(32'h0020A423, 1, CLS_STORE, ALU_ADD,
                    8, 1, 2, 8, 0, 0, 0));
    vq.push_back(mk(32'hFE208EE3, 1, CLS_BRANCH, ALU_SUB,
                    29, 1, 2, 32'hFFFFFFFC, 0, 0, 0));
    vq.push_back(mk(32'h008000EF, 1, CLS_JAL, ALU_ADD,
                    1, 0, 8, 8, 1, 0, 0));
    vq.push_back(mk(32'h00008067, 1, CLS_JALR, ALU_ADD,
                    0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(32'h00412283, 1, CLS_LOAD, ALU_ADD,
                    5, 2, 4, 4, 1, 0, 0));
    vq.push_back(mk(32'h0FF0000F, 1, CLS_MISCMEM, ALU_ADD,
                    0, 0, 31, 32'hFF, 0, 0, 0));
    vq.push_back(mk(32'h00000073, 1, CLS_SYSTEM, ALU_ADD,
                    0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(32'h00100073, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(32'h30200073, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    vq.push_back(mk(32'h00000000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    vq.push_back(mk(32'h0000007F, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    vq.push_back(mk(32'h40001033, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    vq.push_back(mk(32'hFE20AEE3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    vq.push_back(mk(32'h00413283, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    vq.push_back(mk(32'h00208833, 1, CLS_OP, ALU_ADD,
                    16, 1, 2, 0, 1, 0, 1));
    vq.push_back(mk(32'h002087B3, 1, CLS_OP, ALU_ADD,
                    15, 1, 2, 0, 1, 0, 0));
`ifdef JEDRO_1_ZICSR_EN
    vq.push_back(mk(32'h300110F3, 1, CLS_CSR, ALU_ADD,
                    1, 2, 0, 32'h300, 1, 0, 0));
`else
    vq.push_back(mk(32'h300110F3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
`endif

    rst         = 1'b1;
    instr       = 32'd0;
    pc          = 32'd0;
    instr_valid = 1'b0;
    flush       = 1'b0;
    dec_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_dv", dv, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_imm", imm, 0);
    chk("rst_class", cls, 0);
    chk("rst_we", we, 0);
    chk("rst_ill", ill, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ready", ready, 1);
    chk("post_rst_dv", dv, 0);

    // Decode table, one word per cycle with execute always ready.
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      instr_valid = 1'b1;
      instr       = vq[i].instr;
      pc          = 32'h1000 + 32'(4 * i);
      dec_ready   = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_dv", i), dv, 1);
      chk($sformatf("v%0d_ill", i), ill, vq[i].ill);
      chk($sformatf("v%0d_we", i), we, vq[i].we);
      chk($sformatf("v%0d_e_ill", i), e_ill, vq[i].e_ill);
      chk($sformatf("v%0d_pc", i), pc_out,
          32'h1000 + 32'(4 * i));
      if (vq[i].full) begin
        chk($sformatf("v%0d_class", i), cls, vq[i].cls);
        chk($sformatf("v%0d_alu", i), alu, vq[i].alu);
        chk($sformatf("v%0d_f3", i), f3, vq[i].instr[14:12]);
        chk($sformatf("v%0d_rd", i), rd, vq[i].rd);
        chk($sformatf("v%0d_rs1", i), rs1, vq[i].rs1);
        chk($sformatf("v%0d_rs2", i), rs2, vq[i].rs2);
        chk($sformatf("v%0d_imm", i), imm, vq[i].imm);
      end
    end
    @(negedge clk);
    instr_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("drain_dv", dv, 0);

    // Stream of 5 words; execute stalls for the first 3 cycles.
    n_in      = 0;
    n_out     = 0;
    drop_seen = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 40 && n_out < 5; c++) begin
      instr_valid = (n_in < 5);
      instr       = word(n_in);
      pc          = 32'h2000 + 32'(4 * n_in);
      dec_ready   = (c >= 3);
      acc  = instr_valid & ready;
      cons = dv & dec_ready;
      if (cons) begin
        chk($sformatf("order%0d_rd", n_out), rd, n_out + 1);
        chk($sformatf("order%0d_imm", n_out), imm, n_out);
        chk($sformatf("order%0d_pc", n_out), pc_out,
            32'h2000 + 32'(4 * n_out));
      end
      @(posedge clk);
      if (acc) n_in++;
      if (cons) n_out++;
      #1;
      if (acc && n_in == 2 && !drop_seen) begin
        drop_seen = 1'b1;
        chk("ready_drop", ready, 0);
      end
      @(negedge clk);
    end
    chk("stream_out_cnt", n_out, 5);
    chk("stream_drop_seen", drop_seen, 1);
    instr_valid = 1'b0;
    dec_ready   = 1'b1;
    @(posedge clk);
    #1;
    chk("stream_no_dup", dv, 0);

    // Flush with both registers full and a word offered.
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = word(0);
    dec_ready   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    instr = word(1);
    @(posedge clk);
    #1;
    chk("flush_pre_ready", ready, 0);
    @(negedge clk);
    flush = 1'b1;
    instr = word(2);
    @(posedge clk);
    #1;
    chk("flush_dv", dv, 0);
    chk("flush_ready", ready, 1);
    @(negedge clk);
    flush = 1'b0;
    instr = word(3);
    @(posedge clk);
    #1;
    chk("post_flush_dv", dv, 1);
    chk("post_flush_rd", rd, 4);
    @(negedge clk);
    instr_valid = 1'b0;
    dec_ready   = 1'b1;
    @(posedge clk);
    #1;
    chk("post_flush_alone", dv, 0);

    // Reset in the middle of a stalled transfer.
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = word(7);
    dec_ready   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_dv", dv, 0);
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_rd", rd, 0);
    @(negedge clk);
    rst         = 1'b0;
    instr_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_after_dv", dv, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
